// File: rtl/control_param_scheduler_pkg.sv
// Shared constants, state encoding and edit helper
// for the control parameter scheduler.
package control_param_scheduler_pkg;

  localparam int NUM_UNITS = 4;

  localparam logic [1:0] UNIT_F = 2'd0;
  localparam logic [1:0] UNIT_T = 2'd1;
  localparam logic [1:0] UNIT_M = 2'd2;
  localparam logic [1:0] UNIT_V = 2'd3;

  localparam logic [7:0] SAT_MIN = 8'd0;
  localparam logic [7:0] SAT_MAX = 8'd255;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  // Saturating 9-bit edit; up and down together cancel out.
  function automatic logic [7:0] sat_edit(
    input logic [7:0] v,
    input logic [7:0] step,
    input logic       up,
    input logic       dn
  );
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, v};
    r = v;
    if (up && !dn) begin
      s = {1'b0, v} + {1'b0, step};
      r = s[8] ? SAT_MAX : s[7:0];
    end else if (dn && !up) begin
      s = {1'b0, v} - {1'b0, step};
      r = s[8] ? SAT_MIN : s[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/control_param_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: first request after
// the last grant, wrapping around.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       grant_valid
);

  always_comb begin
    logic [1:0] idx;
    grant       = 2'd0;
    grant_valid = 1'b0;
    idx         = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_param_scheduler.sv
// Per-unit settings edited from buttons, pushed one
// word at a time onto a shared valid/ready config bus.
module control_param_scheduler
  import control_param_scheduler_pkg::*;
#(
  parameter int unsigned STEP        = 1,
  parameter int unsigned DEFAULT_VAL = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       cfg_ready,
  output logic       cfg_valid,
  output logic [1:0] cfg_unit,
  output logic [7:0] cfg_data,
  output logic [1:0] sel_unit,
  output logic [7:0] sel_value,
  output logic [3:0] pending
);

  localparam logic [7:0] STEP_L = 8'(STEP);
  localparam logic [7:0] DEF_L  = 8'(DEFAULT_VAL);

  logic [NUM_UNITS-1:0][7:0] set_q, set_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  rr_last_q, rr_last_d;
  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [1:0]  unit_q, unit_d;
  logic [7:0]  data_q, data_d;

  logic [1:0]  gnt;
  logic        gnt_v;
  logic [7:0]  edit_val;
  logic        edit_chg;

  rr_arbiter4 u_arb (
    .req         (pend_q),
    .last        (rr_last_q),
    .grant       (gnt),
    .grant_valid (gnt_v)
  );

  always_comb begin
    set_d     = set_q;
    sel_d     = sel_q + {1'b0, btn_next};
    pend_d    = pend_q;
    rr_last_d = rr_last_q;
    state_d   = state_q;
    valid_d   = valid_q;
    unit_d    = unit_q;
    data_d    = data_q;

    edit_val = sat_edit(set_q[sel_q], STEP_L,
                        btn_up, btn_down);
    edit_chg = (edit_val != set_q[sel_q]);
    if (edit_chg) set_d[sel_q] = edit_val;

    unique case (state_q)
      IDLE: begin
        if (gnt_v) begin
          pend_d[gnt] = 1'b0;
          unit_d      = gnt;
          data_d      = set_q[gnt];
          valid_d     = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cfg_ready) begin
          valid_d   = 1'b0;
          rr_last_d = unit_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edit outranks the clear from a same-cycle grant.
    if (edit_chg) pend_d[sel_q] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      set_q     <= {NUM_UNITS{DEF_L}};
      sel_q     <= UNIT_F;
      pend_q    <= 4'b1111;
      rr_last_q <= UNIT_V;
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      unit_q    <= 2'd0;
      data_q    <= 8'd0;
    end else begin
      set_q     <= set_d;
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      rr_last_q <= rr_last_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      unit_q    <= unit_d;
      data_q    <= data_d;
    end
  end

  assign cfg_valid = valid_q;
  assign cfg_unit  = unit_q;
  assign cfg_data  = data_q;
  assign sel_unit  = sel_q;
  assign sel_value = set_q[sel_q];
  assign pending   = pend_q;

endmodule

// File: tb/tb_control_param_scheduler.sv
// Directed table plus hand sequences for the
// control parameter scheduler.
module tb_control_param_scheduler;

  logic       clock;
  logic       reset;
  logic       btn_next, btn_up, btn_down, cfg_ready;
  logic       cfg_valid;
  logic [1:0] cfg_unit;
  logic [7:0] cfg_data;
  logic [1:0] sel_unit;
  logic [7:0] sel_value;
  logic [3:0] pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  logic [1:0] lu[$];
  logic [7:0] ld[$];
  int         lc[$];

  control_param_scheduler #(
    .STEP        (1),
    .DEFAULT_VAL (128)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .cfg_unit  (cfg_unit),
    .cfg_data  (cfg_data),
    .sel_unit  (sel_unit),
    .sel_value (sel_value),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  // Log each handshake that will complete at the next edge.
  always @(negedge clock) begin
    if (!reset && cfg_valid && cfg_ready) begin
      lu.push_back(cfg_unit);
      ld.push_back(cfg_data);
      lc.push_back(cyc_n);
    end
  end

  typedef struct packed {
    logic       nxt;
    logic       up;
    logic       dn;
    logic       rdy;
    logic [1:0] e_sel;
    logic [7:0] e_val;
    logic [3:0] e_pend;
    logic       e_valid;
    logic [1:0] e_unit;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input logic n, input logic u,
                     input logic d, input logic r);
    btn_next  = n;
    btn_up    = u;
    btn_down  = d;
    cfg_ready = r;
    @(posedge clock);
    #1;
    btn_next = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 64; k++) begin
      if (pending == 4'b0 && !cfg_valid) break;
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk({nm, "_drain"},
        {31'b0, (pending == 4'b0 && !cfg_valid)}, 32'd1);
  endtask

  initial begin
    int n0;
    int last_u2;

    btn_next  = 1'b0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    cfg_ready = 1'b0;
    reset     = 1'b1;

    // nxt up dn rdy | sel val pend valid unit data
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0,
              2'd0, 8'd128, 4'b0000, 1'b0, 2'd3, 8'd128};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0,
              2'd1, 8'd128, 4'b0000, 1'b0, 2'd3, 8'd128};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0,
              2'd1, 8'd129, 4'b0010, 1'b0, 2'd3, 8'd128};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0,
              2'd1, 8'd130, 4'b0010, 1'b1, 2'd1, 8'd129};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0,
              2'd1, 8'd131, 4'b0010, 1'b1, 2'd1, 8'd129};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1,
              2'd1, 8'd131, 4'b0010, 1'b0, 2'd1, 8'd129};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1,
              2'd1, 8'd131, 4'b0000, 1'b1, 2'd1, 8'd131};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1,
              2'd1, 8'd131, 4'b0000, 1'b0, 2'd1, 8'd131};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0,
              2'd1, 8'd131, 4'b0000, 1'b0, 2'd1, 8'd131};

    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_sel",   32'(sel_unit),  32'd0);
    chk("rst_val",   32'(sel_value), 32'd128);
    chk("rst_pend",  32'(pending),   32'hF);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_unit",  32'(cfg_unit),  32'd0);
    chk("rst_data",  32'(cfg_data),  32'd0);

    // Post-reset push of defaults with ready held high
    lu.delete(); ld.delete(); lc.delete();
    reset = 1'b0;
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("boot_cnt", 32'(lu.size()), 32'd4);
    if (lu.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("boot_unit%0d", i), 32'(lu[i]), 32'(i));
        chk($sformatf("boot_data%0d", i), 32'(ld[i]), 32'd128);
        if (i > 0)
          chk($sformatf("boot_gap%0d", i),
              32'(lc[i] - lc[i-1]), 32'd2);
      end
    end
    chk("boot_pend",  32'(pending),   32'd0);
    chk("boot_valid", 32'(cfg_valid), 32'd0);

    // Table: select, edit, hold under backpressure, release
    cfg_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        n0 = lu.size();
        for (int h = 0; h < 10; h++) begin
          cyc(1'b0, 1'b0, 1'b0, 1'b0);
          chk($sformatf("hold%0d_valid", h), 32'(cfg_valid), 32'd1);
          chk($sformatf("hold%0d_unit", h),  32'(cfg_unit),  32'd1);
          chk($sformatf("hold%0d_data", h),  32'(cfg_data),  32'd129);
        end
        chk("hold_nolog", 32'(lu.size() - n0), 32'd0);
      end
      cyc(vt[i].nxt, vt[i].up, vt[i].dn, vt[i].rdy);
      chk($sformatf("v%0d_sel", i),   32'(sel_unit),  32'(vt[i].e_sel));
      chk($sformatf("v%0d_val", i),   32'(sel_value), 32'(vt[i].e_val));
      chk($sformatf("v%0d_pend", i),  32'(pending),   32'(vt[i].e_pend));
      chk($sformatf("v%0d_valid", i), 32'(cfg_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_unit", i),  32'(cfg_unit),  32'(vt[i].e_unit));
      chk($sformatf("v%0d_data", i),  32'(cfg_data),  32'(vt[i].e_data));
    end
    chk("tbl_xfers", 32'(lu.size() - n0), 32'd2);

    // Low saturation on unit 2
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_sel2", 32'(sel_unit), 32'd2);
    repeat (200) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    drain("satlo");
    chk("satlo_val", 32'(sel_value), 32'd0);
    last_u2 = -1;
    foreach (lu[k]) if (lu[k] == 2'd2) last_u2 = int'(ld[k]);
    chk("satlo_lastwr", 32'(last_u2), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("satlo_nopend", 32'(pending),   32'd0);
    chk("satlo_novld",  32'(cfg_valid), 32'd0);
    chk("satlo_hold",   32'(sel_value), 32'd0);

    // High saturation on unit 3
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (130) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    drain("sathi");
    chk("sathi_val", 32'(sel_value), 32'd255);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("sathi_nopend", 32'(pending), 32'd0);

    // Units 3 and 0 both pending with rr_last = 3
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rr_p1", 32'(pending), 32'b1000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_g3_valid", 32'(cfg_valid), 32'd1);
    chk("rr_g3_data",  32'(cfg_data),  32'd254);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rr_wrap_sel", 32'(sel_unit), 32'd0);
    chk("rr_p2",       32'(pending),  32'b1000);
    chk("rr_inflight", 32'(cfg_data), 32'd254);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rr_p3",  32'(pending),   32'b1001);
    chk("rr_v0",  32'(sel_value), 32'd129);
    n0 = lu.size();
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rr_cnt", 32'(lu.size() - n0), 32'd3);
    if (lu.size() - n0 == 3) begin
      chk("rr_w0", {22'b0, lu[n0],   ld[n0]},   {22'b0, 2'd3, 8'd254});
      chk("rr_w1", {22'b0, lu[n0+1], ld[n0+1]}, {22'b0, 2'd0, 8'd129});
      chk("rr_w2", {22'b0, lu[n0+2], ld[n0+2]}, {22'b0, 2'd3, 8'd253});
    end

    // Reset in the middle of a stalled transfer
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mr_pend", 32'(pending), 32'b0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mr_valid", 32'(cfg_valid), 32'd1);
    chk("mr_data",  32'(cfg_data),  32'd130);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mr_rst_valid", 32'(cfg_valid), 32'd0);
    chk("mr_rst_pend",  32'(pending),   32'hF);
    chk("mr_rst_val",   32'(sel_value), 32'd128);
    chk("mr_rst_sel",   32'(sel_unit),  32'd0);
    chk("mr_rst_unit",  32'(cfg_unit),  32'd0);
    chk("mr_rst_data",  32'(cfg_data),  32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
